// File: rtl/avalon_burst_splitter_pkg.sv
// rtl/avalon_burst_splitter_pkg.sv - shared state encodings, widths and burst helper for the burst splitter
package avalon_burst_splitter_pkg;

  localparam int AVM_AW = 30;
  localparam int AVM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  // Beats remaining after the first one; a burstcount of 0 behaves as 1.
  function automatic logic [1:0] beats_after_first(input logic [2:0] burstcount);
    logic [2:0] n;
    n = (burstcount == 3'd0) ? 3'd0 : burstcount - 3'd1;
    return n[1:0];
  endfunction

endpackage

// File: rtl/avalon_pending_counter.sv
// rtl/avalon_pending_counter.sv - saturating outstanding-read counter with an admission limit compare
module avalon_pending_counter #(
  parameter int LIMIT = 8,
  parameter int RW    = 3,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic [RW-1:0] request,
  output logic          over_limit
);

  logic [CW-1:0]    count;
  logic [CW+RW-1:0] total;

  assign total      = {{RW{1'b0}}, count} + {{CW{1'b0}}, request};
  assign over_limit = total > (CW+RW)'(LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && count != CW'(LIMIT)) begin
      count <= count + CW'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/avalon_burst_splitter.sv
// rtl/avalon_burst_splitter.sv - splits 1-4 word Avalon-MM bursts into single-word transactions
module avalon_burst_splitter
  import avalon_burst_splitter_pkg::*;
#(
  parameter int MAX_PENDING = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AVM_AW-1:0] s_address,
  input  logic [AVM_DW-1:0] s_writedata,
  input  logic [3:0]        s_byteenable,
  input  logic [2:0]        s_burstcount,
  input  logic              s_write,
  input  logic              s_read,
  output logic              s_waitrequest,
  output logic              s_readdatavalid,
  output logic [AVM_DW-1:0] s_readdata,
  output logic [AVM_AW-1:0] m_address,
  output logic [AVM_DW-1:0] m_writedata,
  output logic [3:0]        m_byteenable,
  output logic              m_write,
  output logic              m_read,
  input  logic              m_waitrequest,
  input  logic              m_readdatavalid,
  input  logic [AVM_DW-1:0] m_readdata
);

  state_t     state;
  logic [1:0] beats_left;
  logic [1:0] first_beats;
  logic [2:0] read_words;
  logic       slot_free;
  logic       read_blocked;
  logic       take_write;
  logic       take_read;
  logic       issue_read;

  assign first_beats = beats_after_first(s_burstcount);
  assign slot_free   = !(m_read || m_write) || !m_waitrequest;
  // A read still held in the slot is not yet counted as pending, so reserve room for it too.
  assign read_words  = {1'b0, first_beats} + 3'd1 + {2'b00, m_read};
  assign take_write  = (state == ST_IDLE) && s_write && slot_free;
  assign take_read   = (state == ST_IDLE) && s_read && !s_write && slot_free && !read_blocked;
  assign issue_read  = m_read && !m_waitrequest;

  avalon_pending_counter #(
    .LIMIT (MAX_PENDING),
    .RW    (3)
  ) u_pending (
    .clk        (clk),
    .rst        (rst),
    .inc        (issue_read),
    .dec        (m_readdatavalid),
    .request    (read_words),
    .over_limit (read_blocked)
  );

  always_comb begin
    s_waitrequest = 1'b1;
    case (state)
      ST_IDLE:  s_waitrequest = !slot_free || (s_read && !s_write && read_blocked);
      ST_WRITE: s_waitrequest = !slot_free || !s_write;
      default:  s_waitrequest = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      beats_left   <= 2'd0;
      m_address    <= '0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      m_write      <= 1'b0;
      m_read       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_write) begin
            m_address    <= s_address;
            m_writedata  <= s_writedata;
            m_byteenable <= s_byteenable;
            m_write      <= 1'b1;
            m_read       <= 1'b0;
            beats_left   <= first_beats;
            if (first_beats != 2'd0) state <= ST_WRITE;
          end else if (take_read) begin
            m_address    <= s_address;
            m_byteenable <= s_byteenable;
            m_write      <= 1'b0;
            m_read       <= 1'b1;
            beats_left   <= first_beats;
            if (first_beats != 2'd0) state <= ST_READ;
          end else if (!m_waitrequest) begin
            m_write <= 1'b0;
            m_read  <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (s_write && slot_free) begin
            m_address    <= m_address + AVM_AW'(1);
            m_writedata  <= s_writedata;
            m_byteenable <= s_byteenable;
            m_write      <= 1'b1;
            beats_left   <= beats_left - 2'd1;
            if (beats_left == 2'd1) state <= ST_IDLE;
          end else if (!m_waitrequest) begin
            m_write <= 1'b0;
          end
        end
        ST_READ: begin
          if (!m_waitrequest) begin
            if (beats_left != 2'd0) begin
              m_address  <= m_address + AVM_AW'(1);
              beats_left <= beats_left - 2'd1;
            end else begin
              m_read <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
    end else begin
      s_readdatavalid <= m_readdatavalid;
      s_readdata      <= m_readdata;
    end
  end

endmodule
